// File: rtl/score_ctl_pkg.sv
// Shared types and constants for the game-score controller.
// Scores are 2-bit, so a winning score can be at most 3.
package score_ctl_pkg;

  localparam int SCORE_W       = 2;
  localparam int WIN_SCORE_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  // Saturating increment: a score never moves past the limit, so 3 can never wrap to 0.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic [SCORE_W-1:0] lim);
    logic [SCORE_W-1:0] r;
    if (s < lim) begin
      r = s + SCORE_W'(1);
    end else begin
      r = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_ctl_edge_rise.sv
// Rising-edge detector: history flop plus combinational rise = d & ~d_prev.
// The history flop clears on the synchronous active-low reset.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_prev;

  // Holds the input value seen on the previous clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_prev <= 1'b0;
    end else begin
      d_prev <= d;
    end
  end

  assign rise = d & ~d_prev;

endmodule

// File: rtl/score_ctl.sv
// Game-score controller: tracks both scores, freezes the ball for a number of
// frames before each serve, and flags game over when a player reaches WIN_SCORE.
module score_ctl
  import score_ctl_pkg::*;
#(
  parameter int WIN_SCORE    = WIN_SCORE_DEF,
  parameter int SERVE_FRAMES = 60
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vsync_in,
  input  logic               goal_p1,
  input  logic               goal_p2,
  input  logic               restart_btn,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               ball_en,
  output logic               serve_dir,
  output logic               game_over
);

  localparam int CNT_W = (SERVE_FRAMES < 1) ? 1 : $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0]   SERVE_END = CNT_W'(SERVE_FRAMES);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

  logic vsync_rise;
  logic goal1_rise;
  logic goal2_rise;
  logic restart_rise;

  edge_rise u_vsync_rise   (.clk(pclk), .rst(rst), .d(vsync_in),    .rise(vsync_rise));
  edge_rise u_goal1_rise   (.clk(pclk), .rst(rst), .d(goal_p1),     .rise(goal1_rise));
  edge_rise u_goal2_rise   (.clk(pclk), .rst(rst), .d(goal_p2),     .rise(goal2_rise));
  edge_rise u_restart_rise (.clk(pclk), .rst(rst), .d(restart_btn), .rise(restart_rise));

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [SCORE_W-1:0] p1_nxt;
  logic [SCORE_W-1:0] p2_nxt;
  logic               dir_nxt;
  logic               ball_en_nxt;
  logic               over_nxt;

  // Next-state, next-score and serve-counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    p1_nxt    = score_p1;
    p2_nxt    = score_p2;
    dir_nxt   = serve_dir;

    case (state)
      IDLE: begin
        if (restart_rise) begin
          state_nxt = SERVE;
          cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          state_nxt = IDLE;
        end
      end

      SERVE: begin
        if (cnt == SERVE_END) begin
          state_nxt = PLAY;
        end else if (vsync_rise) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          cnt_nxt = cnt;
        end
      end

      // A goal always beats a simultaneous frame tick: the counter restarts from 0.
      PLAY: begin
        if (goal1_rise && !goal2_rise) begin
          p1_nxt    = sat_inc(score_p1, WIN);
          dir_nxt   = 1'b1;
          cnt_nxt   = {CNT_W{1'b0}};
          state_nxt = (p1_nxt == WIN) ? OVER : SERVE;
        end else if (goal2_rise && !goal1_rise) begin
          p2_nxt    = sat_inc(score_p2, WIN);
          dir_nxt   = 1'b0;
          cnt_nxt   = {CNT_W{1'b0}};
          state_nxt = (p2_nxt == WIN) ? OVER : SERVE;
        end else if (goal1_rise && goal2_rise) begin
          cnt_nxt   = {CNT_W{1'b0}};
          state_nxt = SERVE;
        end else begin
          state_nxt = PLAY;
        end
      end

      OVER: begin
        if (restart_rise) begin
          p1_nxt    = {SCORE_W{1'b0}};
          p2_nxt    = {SCORE_W{1'b0}};
          dir_nxt   = 1'b0;
          cnt_nxt   = {CNT_W{1'b0}};
          state_nxt = SERVE;
        end else begin
          state_nxt = OVER;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase

    ball_en_nxt = (state_nxt == PLAY);
    over_nxt    = (state_nxt == OVER);
  end

  // State, counter and all outputs are registered together.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= {CNT_W{1'b0}};
      score_p1  <= {SCORE_W{1'b0}};
      score_p2  <= {SCORE_W{1'b0}};
      ball_en   <= 1'b0;
      serve_dir <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      score_p1  <= p1_nxt;
      score_p2  <= p2_nxt;
      ball_en   <= ball_en_nxt;
      serve_dir <= dir_nxt;
      game_over <= over_nxt;
    end
  end

endmodule

// File: tb/tb_score_ctl.sv
// Directed bench for score_ctl with SERVE_FRAMES=2: table vectors plus
// hand-written sequences for a held goal and a mid-game reset.
module tb_score_ctl;

  logic       pclk = 1'b0;
  logic       rst;
  logic       vsync_in;
  logic       goal_p1;
  logic       goal_p2;
  logic       restart_btn;
  logic [1:0] score_p1;
  logic [1:0] score_p2;
  logic       ball_en;
  logic       serve_dir;
  logic       game_over;

  int tests  = 0;
  int failed = 0;

  // inp = {rst, vsync, goal_p1, goal_p2, restart}; exp = {p1, p2, ball_en, serve_dir, game_over}
  typedef struct packed {
    logic [4:0] inp;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  score_ctl #(.WIN_SCORE(3), .SERVE_FRAMES(2)) dut (
    .pclk       (pclk),
    .rst        (rst),
    .vsync_in   (vsync_in),
    .goal_p1    (goal_p1),
    .goal_p2    (goal_p2),
    .restart_btn(restart_btn),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .ball_en    (ball_en),
    .serve_dir  (serve_dir),
    .game_over  (game_over)
  );

  always #5 pclk = ~pclk;

  function automatic void add(input logic [4:0] inp, input logic [6:0] exp);
    vec_t v;
    v.inp = inp;
    v.exp = exp;
    tbl.push_back(v);
  endfunction

  // Two frame ticks from a fresh SERVE: PLAY must appear exactly after the fourth clock.
  function automatic void add_serve(input logic [1:0] p1, input logic [1:0] p2, input logic sd);
    add(5'b1_1_0_0_0, {p1, p2, 1'b0, sd, 1'b0});
    add(5'b1_0_0_0_0, {p1, p2, 1'b0, sd, 1'b0});
    add(5'b1_1_0_0_0, {p1, p2, 1'b0, sd, 1'b0});
    add(5'b1_0_0_0_0, {p1, p2, 1'b1, sd, 1'b0});
  endfunction

  task automatic apply(input logic [4:0] inp);
    {rst, vsync_in, goal_p1, goal_p2, restart_btn} = inp;
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [6:0] exp);
    logic [6:0] got;
    got = {score_p1, score_p2, ball_en, serve_dir, game_over};
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s[%0d]: got p1=%0d p2=%0d ball_en=%b serve_dir=%b game_over=%b, expected p1=%0d p2=%0d ball_en=%b serve_dir=%b game_over=%b",
               name, idx, got[6:5], got[4:3], got[2], got[1], got[0],
               exp[6:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].inp);
      check(name, i, tbl[i].exp);
    end
    tbl.delete();
  endtask

  initial begin
    {rst, vsync_in, goal_p1, goal_p2, restart_btn} = 5'b0_0_0_0_0;

    // Reset, idle, start and first serve.
    add(5'b0_0_0_0_0, 7'b00_00_0_0_0);
    for (int i = 0; i < 5; i++) add(5'b1_0_0_0_0, 7'b00_00_0_0_0);
    add(5'b1_0_0_0_1, 7'b00_00_0_0_0);
    add(5'b1_0_0_0_1, 7'b00_00_0_0_0);
    add_serve(2'd0, 2'd0, 1'b0);
    run_table("start");

    // goal_p1 held high for 10 clocks counts once.
    for (int i = 0; i < 10; i++) begin
      apply(5'b1_0_1_0_0);
      check("goal_hold", i, 7'b01_00_0_1_0);
    end

    add(5'b1_0_0_0_0, 7'b01_00_0_1_0);
    add_serve(2'd1, 2'd0, 1'b1);
    // restart in PLAY ignored
    add(5'b1_0_0_0_1, 7'b01_00_1_1_0);
    add(5'b1_0_0_0_0, 7'b01_00_1_1_0);
    // simultaneous goals: replay, no score change
    add(5'b1_0_1_1_0, 7'b01_00_0_1_0);
    add(5'b1_0_0_0_0, 7'b01_00_0_1_0);
    add_serve(2'd1, 2'd0, 1'b1);
    // three player-2 goals to game over
    add(5'b1_0_0_1_0, 7'b01_01_0_0_0);
    add(5'b1_0_0_0_0, 7'b01_01_0_0_0);
    add_serve(2'd1, 2'd1, 1'b0);
    add(5'b1_0_0_1_0, 7'b01_10_0_0_0);
    add(5'b1_0_0_0_0, 7'b01_10_0_0_0);
    add_serve(2'd1, 2'd2, 1'b0);
    add(5'b1_0_0_1_0, 7'b01_11_0_0_1);
    add(5'b1_0_0_0_0, 7'b01_11_0_0_1);
    // goals and frame ticks in OVER change nothing
    add(5'b1_0_0_1_0, 7'b01_11_0_0_1);
    add(5'b1_0_0_0_0, 7'b01_11_0_0_1);
    add(5'b1_0_1_0_0, 7'b01_11_0_0_1);
    add(5'b1_0_0_0_0, 7'b01_11_0_0_1);
    add(5'b1_1_0_0_0, 7'b01_11_0_0_1);
    add(5'b1_0_0_0_0, 7'b01_11_0_0_1);
    // restart from OVER
    add(5'b1_0_0_0_1, 7'b00_00_0_0_0);
    add(5'b1_0_0_0_0, 7'b00_00_0_0_0);
    add_serve(2'd0, 2'd0, 1'b0);
    add(5'b1_0_1_0_0, 7'b01_00_0_1_0);
    add(5'b1_0_0_0_0, 7'b01_00_0_1_0);
    add_serve(2'd1, 2'd0, 1'b1);
    // goal and frame tick together: goal wins, counter restarts at 0
    add(5'b1_1_1_0_0, 7'b10_00_0_1_0);
    add(5'b1_0_0_0_0, 7'b10_00_0_1_0);
    add_serve(2'd2, 2'd0, 1'b1);
    run_table("play");

    // Mid-game reset with score_p1=2, then goal edges ignored until restart.
    apply(5'b0_0_0_0_0);
    check("midreset", 0, 7'b00_00_0_0_0);
    apply(5'b1_0_1_0_0);
    check("midreset", 1, 7'b00_00_0_0_0);
    apply(5'b1_0_0_1_0);
    check("midreset", 2, 7'b00_00_0_0_0);
    apply(5'b1_1_0_0_0);
    apply(5'b1_0_0_0_0);
    check("midreset", 3, 7'b00_00_0_0_0);
    apply(5'b1_0_0_0_1);
    check("midreset", 4, 7'b00_00_0_0_0);
    apply(5'b1_0_0_0_0);
    apply(5'b1_1_0_0_0);
    apply(5'b1_0_0_0_0);
    apply(5'b1_1_0_0_0);
    check("midreset", 5, 7'b00_00_0_0_0);
    apply(5'b1_0_0_0_0);
    check("midreset", 6, 7'b00_00_1_0_0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/score_ctl.md
Name: score_ctl

Overview:
- Game-score controller; the writer side of the score interface that the end-screen overlay reads (score_p1/score_p2, 2-bit, game ends at 3).
- Consumes goal events from the ball/collision logic, a frame tick (vsync_in) and the restart button.
- Produces registered scores, ball enable, serve direction and game_over.
- Sits in the pclk domain between ball logic and the VGA overlay chain.

Parameters:
- WIN_SCORE, 3: score that ends the game; must be 1..3 (2-bit scores).
- SERVE_FRAMES, 60: frame ticks of ball freeze before each serve; 0 allowed.

Ports:
- pclk  input  1  pixel clock, only clock.
- rst  input  1  synchronous, active-low reset (asserted when 0).
- vsync_in  input  1  VGA vsync; rising edge = one frame tick.
- goal_p1  input  1  level/pulse from ball logic: player 1 scored.
- goal_p2  input  1  level/pulse from ball logic: player 2 scored.
- restart_btn  input  1  debounced start/restart button, active high.
- score_p1  output  2  player 1 score, registered.
- score_p2  output  2  player 2 score, registered.
- ball_en  output  1  1 = ball may move; 0 = frozen at serve position.
- serve_dir  output  1  1 = serve toward player 2, 0 = toward player 1.
- game_over  output  1  1 while a player holds WIN_SCORE.

Behaviour:
- Reset (rst=0 at a pclk edge): score_p1=0, score_p2=0, ball_en=0, serve_dir=0, game_over=0, state=IDLE, serve counter=0, all edge-detect history regs=0. Reset mid-game discards all scores.
- Edge detection: X_rise = X & ~X_d, where X_d is the value of X registered on the previous edge. Applies to vsync_in, goal_p1, goal_p2 and restart_btn. Levels are never counted; only rising edges.
- All outputs are registered. A state or score change caused by an edge at clock k is visible after clock k.
- IDLE: ball_en=0, game_over=0. restart_btn_rise -> SERVE, counter cleared.
- SERVE: ball_en=0.
  - Counter increments on each vsync_rise.
  - When counter == SERVE_FRAMES -> PLAY (with SERVE_FRAMES=0, PLAY on the next clock).
  - Goal edges are ignored.
- PLAY: ball_en=1.
  - goal_p1_rise only: score_p1+1, serve_dir<=1.
  - goal_p2_rise only: score_p2+1, serve_dir<=0.
  - Both on the same clock: no score change, serve_dir unchanged (point replayed).
  - After any goal edge -> SERVE, counter cleared, ball_en<=0 on the same edge.
  - If the incremented score == WIN_SCORE -> OVER instead of SERVE (same edge).
- OVER: ball_en=0, game_over=1, scores frozen. Goal edges are ignored; scores saturate and never wrap.
  - restart_btn_rise -> both scores cleared, game_over<=0, serve_dir<=0, -> SERVE.
- restart_btn_rise in SERVE or PLAY: ignored.
- Score arithmetic: 2-bit unsigned; increment only while below WIN_SCORE, so no wrap 3->0.
- vsync_rise and a goal edge on the same clock in PLAY: the goal wins, and the counter starts from 0 in SERVE.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE, SERVE, PLAY, OVER (2-bit);
  - WIN_SCORE default;
  - score width constant (2).
- One sub-module, edge_rise: a 1-bit registered rising-edge detector with sync active-low reset. Instantiated four times.
- Serve counter width: $clog2(SERVE_FRAMES+1), minimum 1.

Test Plan:
- Reset then release, no stimulus, 5 clocks -> all outputs 0, ball_en stays 0 (IDLE).
- SERVE_FRAMES=2: restart pulse, then 2 vsync rising edges -> ball_en rises 1 clock after the 2nd edge. Hold goal_p1 high 10 clocks -> score_p1=1 exactly, serve_dir=1, ball_en=0.
- In PLAY, goal_p1 and goal_p2 rise on the same clock -> scores unchanged, ball_en=0, re-serve after 2 frames.
- Three separate goal_p2 edges (with serves between) -> score_p2 = 1, 2, 3; game_over=1 on the third. A further goal_p2 edge -> score_p2 stays 3.
- In OVER, restart_btn rise -> the next clock shows both scores 0, game_over=0, serve_dir=0, ball_en=0; PLAY after SERVE_FRAMES ticks.
- Assert rst=0 for one clock in PLAY with score_p1=2 -> next clock: all outputs 0, IDLE; goal edges ignored until a restart pulse.
